// File: rtl/hex_disp_pkg.sv
// Shared constants for the multiplexed 7-segment display driver: segment patterns,
// the hex glyph table and an index-width helper.
package hex_disp_pkg;

  // Segment order is a..g, left to right; segments are active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Width needed to count 0..n-1; never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment glyph lookup.
module hex_to_seg
  import hex_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [0:6] o_seg
);

  assign o_seg = GLYPH_TABLE[i_nibble];

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed driver for common-anode 7-segment digits sharing one segment bus,
// with dash mode, leading-zero blanking and per-digit blinking.
module hex_display_scan
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int BLINK_DIV  = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] valor,
  input  logic                    modo,
  input  logic                    supr,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [0:6]              saida,
  output logic [NUM_DIGITS-1:0]   dig_n,
  output logic                    frame
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int PW = idx_width(PRESCALE);
  localparam int BW = idx_width(BLINK_DIV);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] PRE_MAX   = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [4*NUM_DIGITS-1:0] r_value;
  logic [PW-1:0]           r_pre;
  logic [IW-1:0]           r_idx;
  logic [BW-1:0]           r_frame_cnt;
  logic                    r_blink_ph;
  logic [0:6]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig_n;
  logic                    r_frame;

  logic                    w_tick;
  logic                    w_wrap;
  logic [3:0]              w_nib_arr [NUM_DIGITS];
  logic                    w_zero_from [NUM_DIGITS+1];
  logic [3:0]              w_nibble;
  logic [0:6]              w_glyph;
  logic                    w_suppress;
  logic                    w_blank;
  logic [0:6]              w_seg_next;
  logic [NUM_DIGITS-1:0]   w_dig_next;

  assign w_tick = (r_pre == PRE_MAX);
  assign w_wrap = w_tick && (r_idx == LAST_IDX);

  // w_zero_from[i] is set when nibble i and every more significant nibble are zero.
  assign w_zero_from[NUM_DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign w_nib_arr[gi]   = r_value[gi*4 +: 4];
      assign w_zero_from[gi] = (w_nib_arr[gi] == 4'h0) && w_zero_from[gi+1];
    end
  endgenerate

  assign w_nibble = w_nib_arr[r_idx];

  hex_to_seg u_hex_to_seg (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  // Digit 0 is excluded so a zero value still shows one "0".
  assign w_suppress = supr && (r_idx != '0) && w_zero_from[r_idx];
  assign w_blank    = blink_mask[r_idx] && r_blink_ph;

  always_comb begin
    w_seg_next = w_glyph;
    if (w_blank)
      w_seg_next = SEG_BLANK;
    else if (!modo)
      w_seg_next = SEG_DASH;
    else if (w_suppress)
      w_seg_next = SEG_BLANK;
  end

  assign w_dig_next = ~(NUM_DIGITS'(1) << r_idx);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_value     <= '0;
      r_pre       <= '0;
      r_idx       <= '0;
      r_frame_cnt <= '0;
      r_blink_ph  <= 1'b0;
      r_seg       <= SEG_BLANK;
      r_dig_n     <= '1;
      r_frame     <= 1'b0;
    end else begin
      if (load)
        r_value <= valor;

      if (w_tick)
        r_pre <= '0;
      else
        r_pre <= r_pre + 1'b1;

      if (w_tick) begin
        if (r_idx == LAST_IDX)
          r_idx <= '0;
        else
          r_idx <= r_idx + 1'b1;
      end

      if (w_wrap) begin
        if (r_frame_cnt == BLINK_MAX) begin
          r_frame_cnt <= '0;
          r_blink_ph  <= ~r_blink_ph;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end

      r_frame <= w_wrap;
      r_seg   <= w_seg_next;
      r_dig_n <= w_dig_next;
    end
  end

  assign saida = r_seg;
  assign dig_n = r_dig_n;
  assign frame = r_frame;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with NUM_DIGITS=4, PRESCALE=4, BLINK_DIV=2.
module tb_hex_display_scan;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] valor = 16'h0000;
  logic        modo = 1'b1;
  logic        supr = 1'b0;
  logic [3:0]  blink_mask = 4'b0000;
  logic [0:6]  saida;
  logic [3:0]  dig_n;
  logic        frame;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] exp_1a3f [4];
  logic [6:0] sup_0040 [4];
  logic [6:0] sup_0000 [4];
  logic [3:0] dig_tab  [4];

  hex_display_scan #(
    .NUM_DIGITS (4),
    .PRESCALE   (4),
    .BLINK_DIV  (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .valor      (valor),
    .modo       (modo),
    .supr       (supr),
    .blink_mask (blink_mask),
    .saida      (saida),
    .dig_n      (dig_n),
    .frame      (frame)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Pulse reset and release it at a falling edge; the next rising edge is E1.
  task automatic restart();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (saida !== 7'b1111111) begin
      n_bad++;
      $display("FAIL reset_saida got=%b want=1111111", saida);
    end
    n_cmp++;
    if (dig_n !== 4'b1111) begin
      n_bad++;
      $display("FAIL reset_dig_n got=%b want=1111", dig_n);
    end
    n_cmp++;
    if (frame !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_frame got=%b want=0", frame);
    end
    $display("test_reset done");
  endtask

  task automatic test_scan();
    int d;
    logic [6:0] es;
    valor = 16'h1A3F; modo = 1'b1; supr = 1'b0; blink_mask = 4'b0000; load = 1'b1;
    restart();
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 1) load = 1'b0;
      d  = ((k - 1) / 4) % 4;
      es = (k == 1) ? 7'b0000001 : exp_1a3f[d];
      n_cmp++;
      if (saida !== es) begin
        n_bad++;
        $display("FAIL scan_saida k=%0d got=%b want=%b", k, saida, es);
      end
      n_cmp++;
      if (dig_n !== dig_tab[d]) begin
        n_bad++;
        $display("FAIL scan_dig_n k=%0d got=%b want=%b", k, dig_n, dig_tab[d]);
      end
      n_cmp++;
      if (frame !== ((k % 16) == 0)) begin
        n_bad++;
        $display("FAIL scan_frame k=%0d got=%b want=%b", k, frame, (k % 16) == 0);
      end
    end
    $display("test_scan done");
  endtask

  task automatic test_suppress();
    int d;
    valor = 16'h0040; modo = 1'b1; supr = 1'b1; load = 1'b1;
    restart();
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) load = 1'b0;
      d = ((k - 1) / 4) % 4;
      n_cmp++;
      if (saida !== sup_0040[d]) begin
        n_bad++;
        $display("FAIL supr_0040 k=%0d got=%b want=%b", k, saida, sup_0040[d]);
      end
    end
    valor = 16'h0000; load = 1'b1;
    restart();
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) load = 1'b0;
      d = ((k - 1) / 4) % 4;
      n_cmp++;
      if (saida !== sup_0000[d]) begin
        n_bad++;
        $display("FAIL supr_0000 k=%0d got=%b want=%b", k, saida, sup_0000[d]);
      end
    end
    supr = 1'b0;
    $display("test_suppress done");
  endtask

  task automatic test_dash();
    valor = 16'h1A3F; modo = 1'b0; supr = 1'b0; load = 1'b1;
    restart();
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) load = 1'b0;
      n_cmp++;
      if (saida !== 7'b1111110) begin
        n_bad++;
        $display("FAIL dash k=%0d got=%b want=1111110", k, saida);
      end
    end
    modo = 1'b1;
    step();
    n_cmp++;
    if (saida !== 7'b0000110) begin
      n_bad++;
      $display("FAIL dash_to_hex got=%b want=0000110", saida);
    end
    n_cmp++;
    if (dig_n !== 4'b1101) begin
      n_bad++;
      $display("FAIL dash_to_hex_dig got=%b want=1101", dig_n);
    end
    $display("test_dash done");
  endtask

  task automatic test_blink();
    int d;
    int f;
    logic [6:0] es;
    valor = 16'h1A3F; modo = 1'b1; supr = 1'b0; blink_mask = 4'b0010; load = 1'b1;
    restart();
    for (int k = 1; k <= 112; k++) begin
      step();
      if (k == 1) load = 1'b0;
      d = ((k - 1) / 4) % 4;
      f = (k - 1) / 16;
      if (d == 1 && (f == 2 || f == 3 || f == 6))
        es = 7'b1111111;
      else if (k >= 97)
        es = 7'b1111110;
      else if (k == 1)
        es = 7'b0000001;
      else
        es = exp_1a3f[d];
      n_cmp++;
      if (saida !== es) begin
        n_bad++;
        $display("FAIL blink k=%0d frame=%0d got=%b want=%b", k, f, saida, es);
      end
      if (k == 96) modo = 1'b0;
    end
    modo = 1'b1; blink_mask = 4'b0000;
    $display("test_blink done");
  endtask

  task automatic test_back_to_back();
    valor = 16'h0000; modo = 1'b1; supr = 1'b0; load = 1'b0;
    restart();
    repeat (3) step();
    valor = 16'h1A3F; load = 1'b1;
    step();
    load = 1'b0;
    n_cmp++;
    if (saida !== 7'b0000001) begin
      n_bad++;
      $display("FAIL b2b_old_saida got=%b want=0000001", saida);
    end
    n_cmp++;
    if (dig_n !== 4'b1110) begin
      n_bad++;
      $display("FAIL b2b_old_dig got=%b want=1110", dig_n);
    end
    step();
    n_cmp++;
    if (saida !== 7'b0000110) begin
      n_bad++;
      $display("FAIL b2b_new_saida got=%b want=0000110", saida);
    end
    n_cmp++;
    if (dig_n !== 4'b1101) begin
      n_bad++;
      $display("FAIL b2b_new_dig got=%b want=1101", dig_n);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_midscan();
    int d;
    valor = 16'h1A3F; modo = 1'b1; supr = 1'b0; load = 1'b1;
    restart();
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 1) load = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (saida !== 7'b1111111) begin
      n_bad++;
      $display("FAIL midreset_saida got=%b want=1111111", saida);
    end
    n_cmp++;
    if (dig_n !== 4'b1111) begin
      n_bad++;
      $display("FAIL midreset_dig got=%b want=1111", dig_n);
    end
    n_cmp++;
    if (frame !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_frame got=%b want=0", frame);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      d = ((k - 1) / 4) % 4;
      n_cmp++;
      if (dig_n !== dig_tab[d]) begin
        n_bad++;
        $display("FAIL restart_dig k=%0d got=%b want=%b", k, dig_n, dig_tab[d]);
      end
      n_cmp++;
      if (frame !== (k == 16)) begin
        n_bad++;
        $display("FAIL restart_frame k=%0d got=%b want=%b", k, frame, k == 16);
      end
      if (k == 1) begin
        n_cmp++;
        if (saida !== 7'b0000001) begin
          n_bad++;
          $display("FAIL restart_saida got=%b want=0000001", saida);
        end
      end
    end
    $display("test_reset_midscan done");
  endtask

  initial begin
    exp_1a3f = '{7'b0111000, 7'b0000110, 7'b0001000, 7'b1001111};
    sup_0040 = '{7'b0000001, 7'b1001100, 7'b1111111, 7'b1111111};
    sup_0000 = '{7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111};
    dig_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    test_reset();
    test_scan();
    test_suppress();
    test_dash();
    test_blink();
    test_back_to_back();
    test_reset_midscan();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
- Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus.
- Captures a NUM_DIGITS-nibble value on a load strobe and scans the digits at a prescaled rate.
- Supports dash mode, leading-zero suppression and per-digit blinking.
- Sits between the datapath result registers and the board display pins; replaces one combinational hex decoder per digit.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- PRESCALE, 50000: clock cycles each digit stays selected; minimum 2.
- BLINK_DIV, 64: full scan frames per blink half-period; minimum 1.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle strobe; captures valor.
- valor  in  4*NUM_DIGITS  value to show; nibble i drives digit i (digit 0 = least significant).
- modo  in  1  1 = hex digits; 0 = every digit shows dash.
- supr  in  1  1 = blank leading zeros.
- blink_mask  in  NUM_DIGITS  bit i = 1 makes digit i blink.
- saida  out  [0:6]  segments a..g, active-low, registered.
- dig_n  out  NUM_DIGITS  digit select, one-hot active-low, registered.
- frame  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

Behaviour:
- Reset (asynchronous, while reset=0):
  - saida=7'b1111111, dig_n all 1, frame=0.
  - value_reg=0, prescaler=0, idx=0, frame_cnt=0, blink_ph=0 (visible).
- Load: if load=1 at an edge, value_reg<=valor. The new value is visible on saida from the next edge that registers the current digit (1-cycle latency). load and the prescaler tick may coincide; both take effect.
- Prescaler: counts 0..PRESCALE-1. tick=1 when count=PRESCALE-1; the count then wraps to 0.
- Scan: on tick, idx<=idx+1, wrapping NUM_DIGITS-1 -> 0. On that wrap:
  - frame=1 for exactly one cycle;
  - frame_cnt increments;
  - when frame_cnt reaches BLINK_DIV-1 it clears and blink_ph toggles.
- Output registers, updated every cycle from the current idx:
  - dig_n: bit idx = 0, all other bits 1. Output latency is 1 cycle after idx changes.
  - saida priority, highest first:
    1. blink_mask[idx]=1 and blink_ph=1 -> 1111111 (blank).
    2. modo=0 -> 1111110 (dash).
    3. supr=1, idx>0, and nibbles idx..NUM_DIGITS-1 all zero -> 1111111.
    4. otherwise the hex glyph of nibble idx.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
- Hex glyphs, 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
- Async inputs (modo, supr, blink_mask) are sampled combinationally each cycle and take effect on the next saida update. No synchroniser is required; callers drive them from clock-domain registers.
- Reset asserted mid-scan: outputs go to the blank/off state immediately. After release, scanning restarts at digit 0 with prescaler=0 and the first frame pulse after NUM_DIGITS*PRESCALE cycles.
- NUM_DIGITS=1: idx stays 0, frame pulses on every tick.

Decomposition:
- Shared package hex_disp_pkg holds:
  - SEG_BLANK=7'b1111111 and SEG_DASH=7'b1111110;
  - the 16-entry glyph constant table;
  - a function for the index width, clog2(NUM_DIGITS) with minimum 1.
- One sub-module, hex_to_seg: combinational 4-bit to 7-bit glyph lookup using the package table. Instantiated once on the muxed nibble.
- Counters, leading-zero detection and output registers stay in the top module.

Test Plan:
- Bench parameters: NUM_DIGITS=4, PRESCALE=4, BLINK_DIV=2.
- Reset/scan: hold reset=0 -> saida=1111111, dig_n=1111. Release, then load valor=16'h1A3F, modo=1 -> dig_n cycles 1110,1101,1011,0111 with 4 cycles each; saida shows 0111000 (F), 0000110 (3), 0001000 (A), 1001111 (1); frame pulses once every 16 cycles.
- Suppression: valor=16'h0040, supr=1 -> digits 0..3 show 0000001, 1001100, 1111111, 1111111. valor=0 -> digit 0 shows 0000001 and digits 1..3 are blank.
- Dash mode: modo=0 with any valor -> all four digits show 1111110. Toggle modo=1 mid-frame -> the next cycle shows the hex glyph.
- Blink: blink_mask=4'b0010 -> digit 1 is blank during frames 2-3 and visible during frames 0-1 and 4-5; other digits are unaffected. Blank takes priority over dash.
- Simultaneous/reset: load and tick in the same cycle -> the new digit shows the new value one cycle later. Assert reset at cycle 7 of the scan -> outputs go blank asynchronously; after release the scan restarts at digit 0 and the first frame pulse occurs at cycle 16.
